// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-port round-robin arbiter feeding one 8N1 UART transmitter
//
// Purpose:
//    Shares a single UART TX line between port 0 (CPU store to the UART TX
//    register) and port 1 (debug/exception reporter). A byte is accepted on a
//    valid/ready handshake, then serialised as start bit, 8 data bits LSB
//    first, optional even parity bit, and stop bit. Every bit lasts
//    CLKS_PER_BIT clock cycles. When both ports request at once, the port
//    that did not win last time is granted.
//
// Optional feature:
//    UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of the 8 data
//    bits) is sent between the data bits and the stop bit (11-bit frame).
//    When undefined, the frame is 10 bits and no parity logic exists.
//
// Ports:
//    clk         system clock, all logic on posedge
//    reset       synchronous active-high reset
//    req0_valid  port 0 has a byte to send
//    req0_data   port 0 byte, sampled only on transfer
//    req0_ready  port 0 byte accepted this cycle when req0_valid=1
//    req1_valid  port 1 has a byte to send
//    req1_data   port 1 byte, sampled only on transfer
//    req1_ready  port 1 byte accepted this cycle when req1_valid=1
//    uart_tx     serial line, idle high, registered
//    tx_busy     frame in progress
//    tx_done     one-cycle pulse on the final cycle of the stop bit
//    grant_id    port owning the current/last frame

module uart_tx_scheduler #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       grant_id
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift_reg, shift_reg_n;
   logic          grant_n;
   logic          last_grant, last_grant_n;
   logic          tx_n;
   logic          done_c;
   logic          idle;
   logic          baud_end;
   logic          xfer0, xfer1;

   assign idle     = (state == S_IDLE);
   assign baud_end = (baud_cnt == BAUD_LAST);

   // Round-robin: a lone requester always wins; on contention the port that
   // did not own the last frame wins. Both readys may be high with no valids.
   assign req0_ready = idle && (!req1_valid || last_grant);
   assign req1_ready = idle && (!req0_valid || !last_grant);
   assign xfer0      = req0_valid && req0_ready;
   assign xfer1      = req1_valid && req1_ready;

   assign tx_busy = !idle;
   assign tx_done = done_c;

   always_comb begin
      state_n      = state;
      baud_cnt_n   = baud_end ? '0 : baud_cnt + CW'(1);
      bit_idx_n    = bit_idx;
      shift_reg_n  = shift_reg;
      grant_n      = grant_id;
      last_grant_n = last_grant;
      done_c       = 1'b0;

      case (state)
         S_IDLE: begin
            baud_cnt_n = '0;
            if (xfer0) begin
               shift_reg_n  = req0_data;
               grant_n      = 1'b0;
               last_grant_n = 1'b0;
               state_n      = S_START;
            end else if (xfer1) begin
               shift_reg_n  = req1_data;
               grant_n      = 1'b1;
               last_grant_n = 1'b1;
               state_n      = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               state_n   = S_DATA;
               bit_idx_n = 3'd0;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) state_n = S_STOP;
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               done_c  = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // uart_tx is registered, so it is computed from the state the FSM is about
   // to enter; this puts the start bit on the line the cycle after transfer.
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         S_START:  tx_n = 1'b0;
         S_DATA:   tx_n = shift_reg_n[bit_idx_n];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_n = ^shift_reg_n;
`endif
         default:  tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= 3'd0;
         shift_reg  <= 8'h00;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         uart_tx    <= 1'b1;
      end else begin
         state      <= state_n;
         baud_cnt   <= baud_cnt_n;
         bit_idx    <= bit_idx_n;
         shift_reg  <= shift_reg_n;
         grant_id   <= grant_n;
         last_grant <= last_grant_n;
         uart_tx    <= tx_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
//
// Purpose:
//    Drives the scheduler with directed sequences and random traffic; a
//    reference model predicts every output on every cycle by expanding each
//    accepted byte into its expected line waveform.
//
// Ports: none (top-level bench).

module tb_uart_tx_scheduler;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int HN = 8192;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req1_ready;
   logic       uart_tx;
   logic       tx_busy;
   logic       tx_done;
   logic       grant_id;

   uart_tx_scheduler #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .uart_tx    (uart_tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic h_tx[HN], h_busy[HN], h_done[HN], h_r0[HN], h_r1[HN], h_gid[HN];

   // Reference model: queue of future line levels for the frame in flight.
   logic q[$];
   logic m_line = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_grant = 1'b0, m_lg = 1'b1;

   typedef struct {
      int   off;
      logic tx;
      logic busy;
      logic done;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic cycle();
      logic e_r0, e_r1, lv;
      logic [7:0] d;
      @(negedge clk);
      h_tx[cyc % HN]   = uart_tx;
      h_busy[cyc % HN] = tx_busy;
      h_done[cyc % HN] = tx_done;
      h_r0[cyc % HN]   = req0_ready;
      h_r1[cyc % HN]   = req1_ready;
      h_gid[cyc % HN]  = grant_id;
      e_r0 = !m_busy && (!req1_valid || m_lg);
      e_r1 = !m_busy && (!req0_valid || !m_lg);
      if (chk_en) begin
         chk("uart_tx", uart_tx, m_line);
         chk("tx_busy", tx_busy, m_busy);
         chk("tx_done", tx_done, m_done);
         chk("grant_id", grant_id, m_grant);
         chk("req0_ready", req0_ready, e_r0);
         chk("req1_ready", req1_ready, e_r1);
         if (req0_valid && req1_valid) chk("one_ready", req0_ready && req1_ready, 0);
      end
      if (reset) begin
         q.delete();
         m_line = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_grant = 1'b0; m_lg = 1'b1;
      end else begin
         if ((req0_valid && e_r0) || (req1_valid && e_r1)) begin
            m_grant = (req0_valid && e_r0) ? 1'b0 : 1'b1;
            m_lg    = m_grant;
            d       = m_grant ? req1_data : req0_data;
            for (int b = 0; b < NB; b++) begin
               if (b == 0)                 lv = 1'b0;
               else if (b <= 8)            lv = d[b-1];
               else if (NB == 11 && b == 9) lv = ^d;
               else                        lv = 1'b1;
               repeat (CPB) q.push_back(lv);
            end
         end
         if (q.size() > 0) begin
            m_line = q.pop_front();
            m_busy = 1'b1;
            m_done = (q.size() == 0);
         end else begin
            m_line = 1'b1; m_busy = 1'b0; m_done = 1'b0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic pulse_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int t, a, dc;
      logic [7:0] bb;
      logic bits[NB];

      // 1. reset held 3 cycles, then idle with no valids
      reset = 1'b1;
      cycle();
      chk_en = 1'b1;
      run(2);
      reset = 1'b0;
      t = cyc;
      cycle();
      chk("rst_uart_tx", h_tx[t % HN], 1);
      chk("rst_tx_busy", h_busy[t % HN], 0);
      chk("rst_tx_done", h_done[t % HN], 0);
      chk("rst_grant_id", h_gid[t % HN], 0);
      chk("rst_ready0", h_r0[t % HN], 1);
      chk("rst_ready1", h_r1[t % HN], 1);

      // 2. single frame from port 0, checked against a constant bit table
`ifdef UART_TX_PARITY_EN
      req0_data = 8'h07;
      bits = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
`else
      req0_data = 8'hA5;
      bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
      for (int k = 0; k < NB; k++) tbl.push_back('{2 + CPB * k, bits[k], 1'b1, 1'b0});
      tbl.push_back('{0, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{CPB * NB - 1, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{CPB * NB, 1'b1, 1'b1, 1'b1});
      tbl.push_back('{CPB * NB + 1, 1'b1, 1'b0, 1'b0});
      req0_valid = 1'b1;
      t = cyc;
      cycle();
      req0_valid = 1'b0;
      chk("t2_ready0", h_r0[t % HN], 1);
      run(CPB * NB + 3);
      foreach (tbl[i]) begin
         chk($sformatf("t2_tx_off%0d", tbl[i].off), h_tx[(t + tbl[i].off) % HN], tbl[i].tx);
         chk($sformatf("t2_busy_off%0d", tbl[i].off), h_busy[(t + tbl[i].off) % HN], tbl[i].busy);
         chk($sformatf("t2_done_off%0d", tbl[i].off), h_done[(t + tbl[i].off) % HN], tbl[i].done);
      end

      // 3. contention: both held valid, alternating grants
      pulse_reset();
      req0_valid = 1'b1; req0_data = 8'h11;
      req1_valid = 1'b1; req1_data = 8'h22;
      t = cyc;
      run(3 * (CPB * NB + 1) + 2);
      req0_valid = 1'b0; req1_valid = 1'b0;
      run(CPB * NB + 2);
      chk("t3_first_r0", h_r0[t % HN], 1);
      chk("t3_first_r1", h_r1[t % HN], 0);
      chk("t3_gid_a", h_gid[(t + 1) % HN], 0);
      chk("t3_r1_b", h_r1[(t + CPB * NB + 1) % HN], 1);
      chk("t3_gid_b", h_gid[(t + CPB * NB + 2) % HN], 1);
      chk("t3_r0_c", h_r0[(t + 2 * (CPB * NB + 1)) % HN], 1);
      chk("t3_gid_c", h_gid[(t + 2 * (CPB * NB + 1) + 1) % HN], 0);

      // 4. port 1 raised mid-frame; data changes before acceptance
      pulse_reset();
      req0_valid = 1'b1; req0_data = 8'h0F;
      t = cyc;
      cycle();
      req0_valid = 1'b0;
      run(10);
      req1_valid = 1'b1; req1_data = 8'h55;
      run(10);
      req1_data = 8'h99;
      run(CPB * NB + 1 - 21);
      a = cyc;
      cycle();
      req1_valid = 1'b0;
      run(CPB * NB + 2);
      chk("t4_r1_held", h_r1[(t + 20) % HN], 0);
      chk("t4_r1_last_stop", h_r1[(t + CPB * NB) % HN], 0);
      chk("t4_accept_cycle", a, t + CPB * NB + 1);
      chk("t4_r1_accept", h_r1[a % HN], 1);
      bb = 8'h99;
      for (int k = 0; k < 8; k++)
         chk($sformatf("t4_bit%0d", k), h_tx[(a + 6 + CPB * k) % HN], bb[k]);

      // 5. reset during data bit 3, then a clean port 1 frame
      pulse_reset();
      req0_valid = 1'b1; req0_data = 8'hFF;
      t = cyc;
      cycle();
      req0_valid = 1'b0;
      run(17);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h3C;
      a = cyc;
      cycle();
      req1_valid = 1'b0;
      run(CPB * NB + 2);
      chk("t5_tx_after_rst", h_tx[a % HN], 1);
      chk("t5_busy_after_rst", h_busy[a % HN], 0);
      chk("t5_done_after_rst", h_done[a % HN], 0);
      chk("t5_r1_after_rst", h_r1[a % HN], 1);
      dc = 0;
      for (int c = t + 18; c < a + CPB * NB; c++) dc += h_done[c % HN];
      chk("t5_no_stray_done", dc, 0);
      chk("t5_done", h_done[(a + CPB * NB) % HN], 1);
      chk("t5_gid", h_gid[(a + 1) % HN], 1);
      bb = 8'h3C;
      for (int k = 0; k < 8; k++)
         chk($sformatf("t5_bit%0d", k), h_tx[(a + 6 + CPB * k) % HN], bb[k]);

      // random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         reset      = ($urandom_range(0, 399) == 0);
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_data  = 8'($urandom);
         req1_data  = 8'($urandom);
         cycle();
      end
      reset = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      run(CPB * NB + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
